inst_decode_queue: RTL and testbench
====================================

// Module: inst_decode_queue
// PURPOSE
//   Registered decode stage between fetch and execute. Accepts {pc, inst} over a
//   valid/ready handshake and splits each word into its fields, type, and
//   sign-extended immediate. Unknown opcodes are flagged illegal; they are never
//   decoded as R-type. Results are buffered in a DEPTH-entry FIFO with flush.
//   A saturating counter tracks how many illegal instructions were accepted.
// PARAMETERS
//   W_SIZE   32  instruction, pc, and immediate width (instruction bits fixed at [31:0])
//   DEPTH    2   FIFO entries; power of two, >= 2
//   CNT_W    16  width of the illegal-instruction counter
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   rst_n      in   1       asynchronous reset, active low
//   flush      in   1       synchronous queue clear
//   in_valid   in   1       upstream has {in_pc, in_inst}
//   in_ready   out  1       queue can accept this cycle
//   in_pc      in   W_SIZE  pc of instruction
//   in_inst    in   W_SIZE  raw instruction word
//   out_valid  out  1       head entry valid
//   out_ready  in   1       downstream consumes head
//   out_pc     out  W_SIZE  head pc
//   opcode     out  7       head inst[6:0]
//   rd         out  5       head inst[11:7]
//   func3      out  3       head inst[14:12]
//   rs1        out  5       head inst[19:15]
//   rs2        out  5       head inst[24:20]
//   func7      out  7       head inst[31:25]
//   inst_type  out  3       R=0 I=1 S=2 B=3 U=4 J=5 C=6 ILL=7
//   imm        out  W_SIZE  decoded immediate
//   illegal    out  1       head inst_type==ILL
//   ill_count  out  CNT_W   illegal instructions accepted, saturating
// BEHAVIOUR
//   Decode (combinational on input, result stored in FIFO):
//     0x33 R; 0x13/0x03/0x67 I; 0x23 S; 0x63 B; 0x37/0x17 U; 0x6F J; 0x73 C.
//     Any other opcode is ILL.
//   imm:
//     I = sext(inst[31:20]).
//     S = sext({inst[31:25],inst[11:7]}).
//     B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//     U = {inst[31:12],12'b0}.
//     J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//     C = zext(inst[31:20]) (CSR address).
//     R and ILL = 0.
//   Handshake and timing:
//     push = in_valid & in_ready; pop = out_valid & out_ready.
//     in_ready = (count < DEPTH), a function of registered count only.
//       There is no bypass when full, even if a pop happens in the same cycle.
//     out_valid = (count != 0).
//     Head outputs are driven directly from storage; they are stable while
//       out_valid & !out_ready.
//     Latency: an entry pushed at edge N is visible at the head after edge N
//       when the queue was empty; otherwise it is in FIFO order.
//   Counters and pointers:
//     Simultaneous push and pop leaves count unchanged; both pointers advance.
//     Pointers wrap modulo DEPTH.
//   flush:
//     On the next edge, count and both pointers go to 0 and out_valid goes to 0.
//     A push in the flush cycle is discarded: it is not stored and not counted.
//     A pop in the flush cycle is ignored.
//     ill_count is not cleared by flush.
//   ill_count:
//     Increments by 1 on every push whose decoded type is ILL.
//     Holds at 2^CNT_W-1.
//   Reset (rst_n low, asynchronous):
//     count, pointers, and ill_count go to 0; all storage goes to 0.
//     Hence out_valid=0, in_ready=1, and every head field reads 0.
//     Reset mid-transfer discards all queued entries.
// TESTING
//   1. Push 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1,
//      type=1, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
//   2. Push 0x00112223 (sw x1,4(x2)) -> type=2, rs1=2, rs2=1, imm=4.
//      Push 0xFE000EE3 (beq x0,x0,-4) -> type=3, imm=0xFFFFFFFC.
//   3. Push 0x0000000B, then 0x00000000 -> both type=7, illegal=1, imm=0,
//      ill_count=2. Preload ill_count near max and confirm it saturates.
//   4. DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd accept.
//      Raise out_ready -> heads pop in order; 3rd accepted only after count<2.
//   5. Queue holds 2 entries; assert flush with in_valid=1 -> next cycle count=0,
//      out_valid=0, pushed entry absent, ill_count unchanged.
//   6. Drop rst_n asynchronously mid-stream -> out_valid=0, in_ready=1, fields=0,
//      and ill_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - registered RV32 decode stage with DEPTH-entry result FIFO and flush
module inst_decode_queue #(
  parameter int W_SIZE = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_SIZE-1:0] in_pc,
  input  logic [W_SIZE-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_SIZE-1:0] out_pc,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        func3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        func7,
  output logic [2:0]        inst_type,
  output logic [W_SIZE-1:0] imm,
  output logic              illegal,
  output logic [CNT_W-1:0]  ill_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_BW = PTR_W + 1;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_C   = 3'd6;
  localparam logic [2:0] T_ILL = 3'd7;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  ill_q, ill_d;

  logic [W_SIZE-1:0] pc_q   [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [2:0]        type_q [DEPTH];
  logic [W_SIZE-1:0] imm_q  [DEPTH];

  logic [31:0]       inst_w;
  logic [2:0]        dec_type;
  logic [W_SIZE-1:0] dec_imm;
  logic [31:0]       head_inst;
  logic              push, pop;

  assign inst_w = in_inst[31:0];

  // Unknown opcodes fall to ILL with a zero immediate, never to R-type.
  always_comb begin
    dec_type = T_ILL;
    dec_imm  = '0;
    case (inst_w[6:0])
      7'h33: dec_type = T_R;
      7'h13, 7'h03, 7'h67: begin
        dec_type = T_I;
        dec_imm  = W_SIZE'($signed(inst_w[31:20]));
      end
      7'h23: begin
        dec_type = T_S;
        dec_imm  = W_SIZE'($signed({inst_w[31:25], inst_w[11:7]}));
      end
      7'h63: begin
        dec_type = T_B;
        dec_imm  = W_SIZE'($signed({inst_w[31], inst_w[7], inst_w[30:25], inst_w[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        dec_type = T_U;
        dec_imm  = W_SIZE'({inst_w[31:12], 12'b0});
      end
      7'h6F: begin
        dec_type = T_J;
        dec_imm  = W_SIZE'($signed({inst_w[31], inst_w[19:12], inst_w[20], inst_w[30:21], 1'b0}));
      end
      7'h73: begin
        dec_type = T_C;
        dec_imm  = W_SIZE'(inst_w[31:20]);
      end
      default: ;
    endcase
  end

  assign in_ready  = (count_q < CNT_BW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ill_d    = ill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_BW'(1);
        2'b01:   count_d = count_q - CNT_BW'(1);
        default: ;
      endcase
      if (push && (dec_type == T_ILL) && (ill_q != {CNT_W{1'b1}}))
        ill_d = ill_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ill_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ill_q    <= ill_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        type_q[i] <= '0;
        imm_q[i]  <= '0;
      end
    end else if (push && !flush) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= inst_w;
      type_q[wr_ptr_q] <= dec_type;
      imm_q[wr_ptr_q]  <= dec_imm;
    end
  end

  // Head fields come straight from the storage slot so they hold while stalled.
  assign head_inst = inst_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign rd        = head_inst[11:7];
  assign func3     = head_inst[14:12];
  assign rs1       = head_inst[19:15];
  assign rs2       = head_inst[24:20];
  assign func7     = head_inst[31:25];
  assign inst_type = type_q[rd_ptr_q];
  assign imm       = imm_q[rd_ptr_q];
  assign illegal   = (type_q[rd_ptr_q] == T_ILL);
  assign ill_count = ill_q;

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - randomized bench for inst_decode_queue against a queue-based model
module tb_inst_decode_queue;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3, inst_type;
  logic [15:0] ill_count;

  logic        in_ready_s, out_valid_s, illegal_s;
  logic [31:0] out_pc_s, imm_s;
  logic [6:0]  opcode_s, func7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  func3_s, inst_type_s;
  logic [2:0]  ill_count_s;

  inst_decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
    .func7(func7), .inst_type(inst_type), .imm(imm), .illegal(illegal), .ill_count(ill_count)
  );

  inst_decode_queue #(.W_SIZE(32), .DEPTH(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_pc(out_pc_s), .opcode(opcode_s), .rd(rd_s), .func3(func3_s), .rs1(rs1_s), .rs2(rs2_s),
    .func7(func7_s), .inst_type(inst_type_s), .imm(imm_s), .illegal(illegal_s), .ill_count(ill_count_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  t;
    logic [31:0] imm;
  } ent_t;

  ent_t mq[$];
  int   ill_m = 0, ill_ms = 0;
  int   vectors = 0, miscompares = 0;
  bit   chk_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mdecode(input logic [31:0] i, output logic [2:0] t, output logic [31:0] im);
    int v;
    v  = 0;
    im = 32'h0;
    case (i[6:0])
      7'h33: t = 3'd0;
      7'h13, 7'h03, 7'h67: begin
        t = 3'd1;
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
        im = 32'(v);
      end
      7'h23: begin
        t = 3'd2;
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (v >= 2048) v -= 4096;
        im = 32'(v);
      end
      7'h63: begin
        t = 3'd3;
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        im = 32'(v);
      end
      7'h37, 7'h17: begin
        t = 3'd4;
        im = i & 32'hFFFFF000;
      end
      7'h6F: begin
        t = 3'd5;
        v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12) + int'(i[20]) * (1 << 11)
            + int'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        im = 32'(v);
      end
      7'h73: begin
        t = 3'd6;
        im = i >> 20;
      end
      default: t = 3'd7;
    endcase
  endfunction

  // Applies the inputs seen at this rising edge to the model.
  task automatic model_edge();
    bit   do_push, do_pop;
    ent_t e;
    if (!rst_n) return;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() != 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc   = in_pc;
        e.inst = in_inst;
        mdecode(in_inst, e.t, e.imm);
        mq.push_back(e);
        if (e.t == 3'd7) begin
          if (ill_m < 65535) ill_m++;
          if (ill_ms < 7) ill_ms++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    cycle();
    in_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("ill_count", ill_count, ill_m);
      chk("ill_count_sat", ill_count_s, ill_ms);
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("opcode", opcode, mq[0].inst[6:0]);
        chk("rd", rd, mq[0].inst[11:7]);
        chk("func3", func3, mq[0].inst[14:12]);
        chk("rs1", rs1, mq[0].inst[19:15]);
        chk("rs2", rs2, mq[0].inst[24:20]);
        chk("func7", func7, mq[0].inst[31:25]);
        chk("inst_type", inst_type, mq[0].t);
        chk("imm", imm, mq[0].imm);
        chk("illegal", illegal, mq[0].t == 3'd7);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_fields"}, {opcode, rd, func3, rs1, rs2, func7}, 0);
    chk({tag, "_type"}, inst_type, 0);
    chk({tag, "_imm"}, imm, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_ill_count"}, ill_count, 0);
    chk({tag, "_ill_count_s"}, ill_count_s, 0);
  endtask

  logic [6:0] opc_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    push1(32'h1000, 32'hFFF10093, 1'b1);
    chk("t1_valid", out_valid, 1);
    chk("t1_type", inst_type, 1);
    chk("t1_rd", rd, 1);
    chk("t1_rs1", rs1, 2);
    chk("t1_imm", imm, 32'hFFFFFFFF);
    chk("t1_illegal", illegal, 0);

    push1(32'h1004, 32'h00112223, 1'b1);
    chk("t2_sw_type", inst_type, 2);
    chk("t2_sw_rs1", rs1, 2);
    chk("t2_sw_rs2", rs2, 1);
    chk("t2_sw_imm", imm, 4);
    push1(32'h1008, 32'hFE000EE3, 1'b1);
    chk("t2_beq_type", inst_type, 3);
    chk("t2_beq_imm", imm, 32'hFFFFFFFC);

    push1(32'h100C, 32'h0000000B, 1'b1);
    chk("t3_a_type", inst_type, 7);
    chk("t3_a_illegal", illegal, 1);
    chk("t3_a_imm", imm, 0);
    push1(32'h1010, 32'h00000000, 1'b1);
    chk("t3_b_type", inst_type, 7);
    chk("t3_b_illegal", illegal, 1);
    chk("t3_b_imm", imm, 0);
    chk("t3_ill_count", ill_count, 2);

    for (int k = 0; k < 10; k++) push1(32'h2000 + 32'(k * 4), 32'h0000007F, 1'b1);
    chk("t3_ill_count_12", ill_count, 12);
    chk("t3_ill_sat", ill_count_s, 7);
    out_ready = 1'b1;
    cycle();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00000033;
    in_pc     = 32'h100;
    cycle();
    in_pc = 32'h104;
    cycle();
    chk("t4_full_ready", in_ready, 0);
    in_pc = 32'h108;
    cycle();
    chk("t4_stall_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    cycle();
    chk("t4_pop1_pc", out_pc, 32'h104);
    cycle();
    chk("t4_pop2_pc", out_pc, 32'h108);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    push1(32'h10C, 32'h00000013, 1'b0);
    chk("t5_two_held", in_ready, 0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h0000000B;
    out_ready = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_ready", in_ready, 1);
    chk("t5_flush_ill", ill_count, 12);
    cycle();
    chk("t5_absent", out_valid, 0);

    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_inst   = 32'h0000000B;
        cycle();
        cycle();
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        mq.delete();
        ill_m  = 0;
        ill_ms = 0;
        #1;
        check_reset_state("t6_async");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      r = $urandom();
      if ($urandom_range(0, 4) == 0) opc = r[6:0];
      else opc = opc_tab[$urandom_range(0, 9)];
      in_inst   = {r[31:7], opc};
      in_pc     = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
